// File: rtl/rr_index_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | rr_index_arbiter_if : request/release/grant bundle for rr_index_arbiter  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface rr_index_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  // "release" is a reserved word in SystemVerilog, so the release strobe is rel.
  logic [N-1:0]     req;
  logic             rel;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic             timeout;

  modport master (output req, output rel, input idx, input valid, input timeout);
  modport slave  (input req, input rel, output idx, output valid, output timeout);
endinterface

`default_nettype wire

// File: rtl/rr_index_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_index_arbiter : 8-way round-robin arbiter, registered grant index     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_index_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15
) (
  input  wire                clk,
  input  wire                rst,
  rr_index_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] pick;
  logic             found;
  logic [IDX_W-1:0] cand;

  // Circular scan starting at ptr; index arithmetic wraps naturally at N=8.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    cand  = ptr_q;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = pick;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.rel || !bus.req[idx_q]) begin
          state_d = S_IDLE;
          ptr_d   = idx_q + IDX_W'(1);
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d   = S_IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.idx     = idx_q;
  assign bus.valid   = (state_q == S_GRANT);
  assign bus.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_index_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_rr_index_arbiter : directed + randomized checks against a rule model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rr_index_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rr_index_arbiter_if ifc ();

  rr_index_arbiter #(.N(8), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a grant is "busy" for m_held cycles so far, scanning
  // circularly from m_ptr when idle.
  bit m_busy = 0;
  int m_ptr  = 0;
  int m_idx  = 0;
  int m_held = 0;
  bit m_to   = 0;

  task automatic model_step(input bit r, input logic [7:0] q, input bit l);
    bit ended;
    ended = 0;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_idx = 0; m_held = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (q != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (!m_busy && q[(m_ptr + k) % 8]) begin
              m_idx  = (m_ptr + k) % 8;
              m_busy = 1;
              m_held = 1;
            end
          end
        end
      end else if (l || !q[m_idx]) begin
        ended = 1;
      end else if (m_held == MAX_HOLD) begin
        ended = 1;
        m_to  = 1;
      end else begin
        m_held++;
      end
      if (ended) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [7:0] q, input bit l);
    @(negedge clk);
    rst     = r;
    ifc.req = q;
    ifc.rel = l;
    @(posedge clk);
    model_step(r, q, l);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 8'hFF, 1'b0);
      total++;
      if (ifc.idx !== 3'd0 || ifc.valid !== 1'b0 || ifc.timeout !== 1'b0) begin
        bad++;
        $display("FAIL reset_state got idx=%0d valid=%0b timeout=%0b want 0/0/0",
                 ifc.idx, ifc.valid, ifc.timeout);
      end
    end
    cycle(1'b0, 8'hFF, 1'b0);
    total++;
    if (ifc.idx !== 3'd0 || ifc.valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant got idx=%0d valid=%0b want idx=0 valid=1",
               ifc.idx, ifc.valid);
    end
    cycle(1'b0, 8'hFF, 1'b1);
  endtask

  task automatic test_rotation();
    cycle(1'b1, 8'hFF, 1'b0);
    for (int g = 0; g < 9; g++) begin
      cycle(1'b0, 8'hFF, 1'b0);
      total++;
      if (ifc.valid !== 1'b1 || ifc.idx !== 3'(g % 8)) begin
        bad++;
        $display("FAIL rotation_grant%0d got idx=%0d valid=%0b want idx=%0d valid=1",
                 g, ifc.idx, ifc.valid, g % 8);
      end
      cycle(1'b0, 8'hFF, 1'b1);
      total++;
      if (ifc.valid !== 1'b0 || ifc.timeout !== 1'b0) begin
        bad++;
        $display("FAIL rotation_gap%0d got valid=%0b timeout=%0b want 0/0",
                 g, ifc.valid, ifc.timeout);
      end
    end
  endtask

  task automatic test_wrap_skip();
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h40, 1'b0);
    total++;
    if (ifc.idx !== 3'd6 || ifc.valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_setup got idx=%0d valid=%0b want idx=6 valid=1", ifc.idx, ifc.valid);
    end
    cycle(1'b0, 8'h40, 1'b1);
    cycle(1'b0, 8'h21, 1'b0);
    total++;
    if (ifc.idx !== 3'd0 || ifc.valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_to_0 got idx=%0d valid=%0b want idx=0 valid=1", ifc.idx, ifc.valid);
    end
    cycle(1'b0, 8'h21, 1'b1);
    cycle(1'b0, 8'h21, 1'b0);
    total++;
    if (ifc.idx !== 3'd5 || ifc.valid !== 1'b1) begin
      bad++;
      $display("FAIL skip_to_5 got idx=%0d valid=%0b want idx=5 valid=1", ifc.idx, ifc.valid);
    end
    cycle(1'b0, 8'h21, 1'b1);
  endtask

  task automatic test_timeout();
    for (int c = 0; c < MAX_HOLD; c++) begin
      cycle(1'b0, 8'h08, 1'b0);
      total++;
      if (ifc.valid !== 1'b1 || ifc.idx !== 3'd3 || ifc.timeout !== 1'b0) begin
        bad++;
        $display("FAIL timeout_hold%0d got idx=%0d valid=%0b timeout=%0b want 3/1/0",
                 c, ifc.idx, ifc.valid, ifc.timeout);
      end
    end
    cycle(1'b0, 8'h08, 1'b0);
    total++;
    if (ifc.valid !== 1'b0 || ifc.timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_pulse got valid=%0b timeout=%0b want valid=0 timeout=1",
               ifc.valid, ifc.timeout);
    end
    cycle(1'b0, 8'h08, 1'b0);
    total++;
    if (ifc.valid !== 1'b1 || ifc.idx !== 3'd3 || ifc.timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_regrant got idx=%0d valid=%0b timeout=%0b want 3/1/0",
               ifc.idx, ifc.valid, ifc.timeout);
    end
    cycle(1'b0, 8'h08, 1'b1);
  endtask

  task automatic test_drop_and_simul();
    cycle(1'b0, 8'h10, 1'b0);
    cycle(1'b0, 8'h10, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    total++;
    if (ifc.valid !== 1'b0 || ifc.timeout !== 1'b0) begin
      bad++;
      $display("FAIL drop_end got valid=%0b timeout=%0b want 0/0", ifc.valid, ifc.timeout);
    end
    cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (ifc.valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_release got valid=%0b want 0", ifc.valid);
    end
    for (int c = 0; c < MAX_HOLD; c++) cycle(1'b0, 8'h10, 1'b0);
    total++;
    if (ifc.valid !== 1'b1 || ifc.idx !== 3'd4) begin
      bad++;
      $display("FAIL simul_setup got idx=%0d valid=%0b want idx=4 valid=1", ifc.idx, ifc.valid);
    end
    cycle(1'b0, 8'h10, 1'b1);
    total++;
    if (ifc.valid !== 1'b0 || ifc.timeout !== 1'b0) begin
      bad++;
      $display("FAIL simul_release got valid=%0b timeout=%0b want 0/0", ifc.valid, ifc.timeout);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 8'h20, 1'b0);
    total++;
    if (ifc.valid !== 1'b1 || ifc.idx !== 3'd5) begin
      bad++;
      $display("FAIL midrst_setup got idx=%0d valid=%0b want idx=5 valid=1", ifc.idx, ifc.valid);
    end
    cycle(1'b1, 8'hFF, 1'b0);
    total++;
    if (ifc.valid !== 1'b0 || ifc.idx !== 3'd0 || ifc.timeout !== 1'b0) begin
      bad++;
      $display("FAIL midrst_clear got idx=%0d valid=%0b timeout=%0b want 0/0/0",
               ifc.idx, ifc.valid, ifc.timeout);
    end
    cycle(1'b0, 8'hFF, 1'b0);
    total++;
    if (ifc.valid !== 1'b1 || ifc.idx !== 3'd0) begin
      bad++;
      $display("FAIL midrst_ptr0 got idx=%0d valid=%0b want idx=0 valid=1", ifc.idx, ifc.valid);
    end
    cycle(1'b0, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] q;
    bit         r;
    bit         l;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 49) == 0);
      q = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom & $urandom);
      l = ($urandom_range(0, 3) == 0);
      cycle(r, q, l);
      total++;
      if (ifc.valid !== m_busy || ifc.idx !== 3'(m_idx) || ifc.timeout !== m_to) begin
        bad++;
        $display("FAIL random_c%0d got idx=%0d valid=%0b timeout=%0b want %0d/%0b/%0b",
                 n, ifc.idx, ifc.valid, ifc.timeout, m_idx, m_busy, m_to);
      end
    end
  endtask

  initial begin
    ifc.req = 8'h00;
    ifc.rel = 1'b0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_timeout();
    test_drop_and_simul();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
